mpu_thread_mapman: RTL and testbench

//  Map-manager responder for MPU thread storage: answers store requests from the thread memory,

---
 rtl/mpu_thread_mapman_pkg.sv | 27 ++
 rtl/mpu_thread_mapman_ringbuffctrl.sv | 43 ++++
 rtl/mpu_thread_mapman.sv | 208 ++++++++++++++++++++
 tb/tb_mpu_thread_mapman.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_thread_mapman_pkg.sv
// Shared types for the MPU thread map manager: address/ID types, table entry and FSM encoding.
package pkg_mpu;

    localparam int NUM_ENTRY_MAPMAN = 16;
    localparam int SIZE_THREAD_MEM  = 256;

    // One extra bit so a used-size equal to the whole memory is representable.
    localparam int MPU_ADDR_W = $clog2(SIZE_THREAD_MEM) + 1;
    localparam int ID_W       = 8;

    typedef logic [MPU_ADDR_W-1:0] mpu_address_t;
    typedef logic [ID_W-1:0]       id_t;

    typedef logic [1:0] fsm_mapman_t;
    localparam logic [1:0] MM_IDLE  = 2'd0;
    localparam logic [1:0] MM_CMP   = 2'd1;
    localparam logic [1:0] MM_GRANT = 2'd2;
    localparam logic [1:0] MM_DONE  = 2'd3;

    typedef struct packed {
        logic         valid;
        id_t          id;
        mpu_address_t base;
        mpu_address_t length;
    } mapman_entry_t;

endpackage

// File: rtl/mpu_thread_mapman_ringbuffctrl.sv
// Head/tail index control for the thread table ring; callers only push when an entry is free.
module RingBuffCTRL #(
    parameter int NUM_ENTRY = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    output logic [$clog2(NUM_ENTRY)-1:0] head,
    output logic [$clog2(NUM_ENTRY)-1:0] tail,
    output logic                         full,
    output logic                         empty
);

    localparam int IW = $clog2(NUM_ENTRY);
    localparam logic [IW:0] NUM_ENTRY_W = (IW + 1)'(NUM_ENTRY);

    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;
    logic [IW:0]   count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop)  head_q <= head_q + 1'b1;
            if (push) tail_q <= tail_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign full  = (count_q == NUM_ENTRY_W);
    assign empty = (count_q == '0);

endmodule

// File: rtl/mpu_thread_mapman.sv
// Map manager for MPU thread storage: store grants, dispatch lookups, in-order releases.
// Optional activity counters are compiled in with MPU_MAPMAN_STATS_EN.
module mpu_thread_mapman
    import pkg_mpu::*;
#(
    parameter int NUM_ENTRY = NUM_ENTRY_MAPMAN,
    parameter int SIZE_MEM  = SIZE_THREAD_MEM
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         I_Req_St,
    input  id_t          I_ThreadID_St,
    input  mpu_address_t I_Length_St,
    output logic         O_Ack_St,
    output logic         O_Dup_St,
    output mpu_address_t O_Base_St,
    output mpu_address_t O_Used_Size,
    input  logic         I_Req_Lookup,
    input  id_t          I_ThreadID_Lookup,
    output logic         O_Valid_Lookup,
    output logic         O_Hit_Lookup,
    output mpu_address_t O_Base_Lookup,
    output mpu_address_t O_Length_Lookup,
    input  logic         I_Req_Release,
    input  id_t          I_ThreadID_Release,
    output logic         O_Err_Release,
    output logic         O_Full,
    output fsm_mapman_t  O_Dbg_State
`ifdef MPU_MAPMAN_STATS_EN
    ,
    output logic [31:0]  O_Num_Alloc,
    output logic [31:0]  O_Num_Stall
`endif
);

    localparam int IW = $clog2(NUM_ENTRY);
    localparam logic [MPU_ADDR_W:0] SIZE_MEM_W = (MPU_ADDR_W + 1)'(SIZE_MEM);
    localparam mpu_address_t        SIZE_MEM_A = mpu_address_t'(SIZE_MEM);

    mapman_entry_t table_q [NUM_ENTRY];
    fsm_mapman_t   state_q;
    id_t           st_id_q;
    mpu_address_t  st_len_q;
    logic          hit_q;
    mpu_address_t  hit_base_q;
    mpu_address_t  alloc_ptr_q;
    mpu_address_t  used_q;

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic          full;
    logic          empty;

    logic                  cmp_hit;
    mpu_address_t          cmp_base;
    logic                  lk_hit;
    mpu_address_t          lk_base;
    mpu_address_t          lk_len;
    logic                  rel_fire;
    logic                  alloc_fire;
    logic                  ack;
    logic [MPU_ADDR_W:0]   need;
    logic                  fits;
    mpu_address_t          ptr_sum;
    mpu_address_t          alloc_nxt;
    logic                  valid_lk_q;
    logic                  hit_lk_q;
    mpu_address_t          base_lk_q;
    mpu_address_t          len_lk_q;
    logic                  err_q;

    RingBuffCTRL #(.NUM_ENTRY(NUM_ENTRY)) u_ring (
        .clock (clock),
        .reset (reset),
        .push  (alloc_fire),
        .pop   (rel_fire),
        .head  (head),
        .tail  (tail),
        .full  (full),
        .empty (empty)
    );

    // IDs are unique in the table, so at most one entry can match either search.
    always_comb begin
        cmp_hit  = 1'b0;
        cmp_base = '0;
        lk_hit   = 1'b0;
        lk_base  = '0;
        lk_len   = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (table_q[i].valid && table_q[i].id == st_id_q) begin
                cmp_hit  = 1'b1;
                cmp_base = table_q[i].base;
            end
            if (table_q[i].valid && table_q[i].id == I_ThreadID_Lookup) begin
                lk_hit  = 1'b1;
                lk_base = table_q[i].base;
                lk_len  = table_q[i].length;
            end
        end
    end

    // A same-cycle release frees a table slot for the grant, but its words only count next cycle.
    always_comb begin
        rel_fire   = I_Req_Release && !empty;
        need       = {1'b0, used_q} + {1'b0, st_len_q};
        fits       = (need <= SIZE_MEM_W);
        alloc_fire = (state_q == MM_GRANT) && !hit_q && (!full || rel_fire) && fits;
        ack        = (state_q == MM_GRANT) && (hit_q || alloc_fire);
        ptr_sum    = alloc_ptr_q + st_len_q;
        alloc_nxt  = (ptr_sum >= SIZE_MEM_A) ? ptr_sum - SIZE_MEM_A : ptr_sum;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= MM_IDLE;
            st_id_q    <= '0;
            st_len_q   <= '0;
            hit_q      <= 1'b0;
            hit_base_q <= '0;
        end else begin
            case (state_q)
                MM_IDLE: begin
                    if (I_Req_St) begin
                        st_id_q  <= I_ThreadID_St;
                        st_len_q <= I_Length_St;
                        state_q  <= MM_CMP;
                    end
                end
                MM_CMP: begin
                    hit_q      <= cmp_hit;
                    hit_base_q <= cmp_base;
                    state_q    <= MM_GRANT;
                end
                MM_GRANT: begin
                    if (ack) state_q <= MM_DONE;
                end
                default: begin
                    if (!I_Req_St) state_q <= MM_IDLE;
                end
            endcase
        end
    end

    // When the ring is full, head and tail alias: the release clears the slot and the grant refills it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRY; i++) table_q[i] <= '0;
            alloc_ptr_q <= '0;
            used_q      <= '0;
        end else begin
            if (rel_fire) table_q[head].valid <= 1'b0;
            if (alloc_fire) begin
                table_q[tail] <= '{valid: 1'b1, id: st_id_q, base: alloc_ptr_q, length: st_len_q};
                alloc_ptr_q   <= alloc_nxt;
            end
            used_q <= used_q - (rel_fire ? table_q[head].length : '0)
                             + (alloc_fire ? st_len_q : '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_lk_q <= 1'b0;
            hit_lk_q   <= 1'b0;
            base_lk_q  <= '0;
            len_lk_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_lk_q <= I_Req_Lookup;
            hit_lk_q   <= I_Req_Lookup && lk_hit;
            base_lk_q  <= I_Req_Lookup ? lk_base : '0;
            len_lk_q   <= I_Req_Lookup ? lk_len : '0;
            err_q      <= I_Req_Release && (empty || table_q[head].id != I_ThreadID_Release);
        end
    end

    assign O_Ack_St        = ack;
    assign O_Dup_St        = ack && hit_q;
    assign O_Base_St       = ack ? (hit_q ? hit_base_q : alloc_ptr_q) : '0;
    assign O_Used_Size     = used_q;
    assign O_Valid_Lookup  = valid_lk_q;
    assign O_Hit_Lookup    = hit_lk_q;
    assign O_Base_Lookup   = base_lk_q;
    assign O_Length_Lookup = len_lk_q;
    assign O_Err_Release   = err_q;
    assign O_Full          = full;
    assign O_Dbg_State     = state_q;

`ifdef MPU_MAPMAN_STATS_EN
    logic [31:0] num_alloc_q;
    logic [31:0] num_stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num_alloc_q <= '0;
            num_stall_q <= '0;
        end else begin
            if (alloc_fire && num_alloc_q != '1) num_alloc_q <= num_alloc_q + 1'b1;
            if ((state_q == MM_GRANT) && !ack && num_stall_q != '1) num_stall_q <= num_stall_q + 1'b1;
        end
    end

    assign O_Num_Alloc = num_alloc_q;
    assign O_Num_Stall = num_stall_q;
`endif

endmodule

// File: tb/tb_mpu_thread_mapman.sv
// Bench for mpu_thread_mapman with a 64-word memory and 16-entry table.
module tb_mpu_thread_mapman;
    import pkg_mpu::*;

    localparam int MEM = 64;

    logic         clock;
    logic         reset;
    logic         I_Req_St;
    id_t          I_ThreadID_St;
    mpu_address_t I_Length_St;
    logic         O_Ack_St;
    logic         O_Dup_St;
    mpu_address_t O_Base_St;
    mpu_address_t O_Used_Size;
    logic         I_Req_Lookup;
    id_t          I_ThreadID_Lookup;
    logic         O_Valid_Lookup;
    logic         O_Hit_Lookup;
    mpu_address_t O_Base_Lookup;
    mpu_address_t O_Length_Lookup;
    logic         I_Req_Release;
    id_t          I_ThreadID_Release;
    logic         O_Err_Release;
    logic         O_Full;
    fsm_mapman_t  O_Dbg_State;
`ifdef MPU_MAPMAN_STATS_EN
    logic [31:0]  O_Num_Alloc;
    logic [31:0]  O_Num_Stall;
`endif

    mpu_thread_mapman #(.NUM_ENTRY(16), .SIZE_MEM(MEM)) dut (
        .clock              (clock),
        .reset              (reset),
        .I_Req_St           (I_Req_St),
        .I_ThreadID_St      (I_ThreadID_St),
        .I_Length_St        (I_Length_St),
        .O_Ack_St           (O_Ack_St),
        .O_Dup_St           (O_Dup_St),
        .O_Base_St          (O_Base_St),
        .O_Used_Size        (O_Used_Size),
        .I_Req_Lookup       (I_Req_Lookup),
        .I_ThreadID_Lookup  (I_ThreadID_Lookup),
        .O_Valid_Lookup     (O_Valid_Lookup),
        .O_Hit_Lookup       (O_Hit_Lookup),
        .O_Base_Lookup      (O_Base_Lookup),
        .O_Length_Lookup    (O_Length_Lookup),
        .I_Req_Release      (I_Req_Release),
        .I_ThreadID_Release (I_ThreadID_Release),
        .O_Err_Release      (O_Err_Release),
        .O_Full             (O_Full),
        .O_Dbg_State        (O_Dbg_State)
`ifdef MPU_MAPMAN_STATS_EN
        ,
        .O_Num_Alloc        (O_Num_Alloc),
        .O_Num_Stall        (O_Num_Stall)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard entries are {dup, base}
    logic [MPU_ADDR_W:0] exp_q[$];

    typedef struct {
        id_t          id;
        mpu_address_t len;
        mpu_address_t base;
        logic         dup;
        mpu_address_t used;
    } st_vec_t;

    st_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        I_Req_St = 1'b0;
        I_ThreadID_St = '0;
        I_Length_St = '0;
        I_Req_Lookup = 1'b0;
        I_ThreadID_Lookup = '0;
        I_Req_Release = 1'b0;
        I_ThreadID_Release = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_store(input id_t id, input mpu_address_t len, input logic exp_dup,
                               input mpu_address_t exp_base, input logic push);
        I_ThreadID_St = id;
        I_Length_St   = len;
        I_Req_St      = 1'b1;
        if (push) exp_q.push_back({exp_dup, exp_base});
    endtask

    task automatic take_ack(input string name);
        logic [MPU_ADDR_W:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected_ack: got ack with base %0d, expected no ack", name, O_Base_St);
        end else begin
            e = exp_q.pop_front();
            check({name, "_base"}, 32'(O_Base_St), 32'(e[MPU_ADDR_W-1:0]));
            check({name, "_dup"}, 32'(O_Dup_St), 32'(e[MPU_ADDR_W]));
        end
    endtask

    task automatic wait_ack(input int budget, input int exp_lat, input string name);
        int lat;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (O_Ack_St === 1'b1) begin
                lat = k;
                take_ack(name);
                tick();
                break;
            end
            tick();
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack within %0d cycles, expected ack", name, budget);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    task automatic finish_store();
        I_Req_St = 1'b0;
        tick();
    endtask

    task automatic expect_stall(input int cycles, input string name);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            check({name, "_noack"}, 32'(O_Ack_St), 32'd0);
            tick();
        end
    endtask

    task automatic lookup(input id_t id, input logic hit, input mpu_address_t base,
                          input mpu_address_t len, input string name);
        I_ThreadID_Lookup = id;
        I_Req_Lookup = 1'b1;
        tick();
        I_Req_Lookup = 1'b0;
        check({name, "_valid"}, 32'(O_Valid_Lookup), 32'd1);
        check({name, "_hit"}, 32'(O_Hit_Lookup), 32'(hit));
        check({name, "_base"}, 32'(O_Base_Lookup), 32'(base));
        check({name, "_len"}, 32'(O_Length_Lookup), 32'(len));
        tick();
        check({name, "_valid_drop"}, 32'(O_Valid_Lookup), 32'd0);
    endtask

    int m_alloc;
    int m_used;

    initial begin
        //            id    len  base dup used
        vecs[0] = '{8'd5,  9'd10, 9'd0,  1'b0, 9'd10};
        vecs[1] = '{8'd5,  9'd4,  9'd0,  1'b1, 9'd10};
        vecs[2] = '{8'd7,  9'd20, 9'd10, 1'b0, 9'd30};
        vecs[3] = '{8'd12, 9'd0,  9'd30, 1'b0, 9'd30};
        vecs[4] = '{8'd11, 9'd30, 9'd30, 1'b0, 9'd60};

        do_reset();
        check("rst_ack", 32'(O_Ack_St), 32'd0);
        check("rst_used", 32'(O_Used_Size), 32'd0);
        check("rst_full", 32'(O_Full), 32'd0);
        check("rst_state", 32'(O_Dbg_State), 32'(MM_IDLE));
        check("rst_lk_valid", 32'(O_Valid_Lookup), 32'd0);
        check("rst_err", 32'(O_Err_Release), 32'd0);

        // table-driven stores from reset, incl. duplicate ID and zero length
        foreach (vecs[i]) begin
            start_store(vecs[i].id, vecs[i].len, vecs[i].dup, vecs[i].base, 1'b1);
            wait_ack(6, 2, $sformatf("store%0d", i));
            finish_store();
            check($sformatf("store%0d_used", i), 32'(O_Used_Size), 32'(vecs[i].used));
            check($sformatf("store%0d_state", i), 32'(O_Dbg_State), 32'(MM_IDLE));
        end

        lookup(8'd5, 1'b1, 9'd0, 9'd10, "lk5");
        lookup(8'd9, 1'b0, 9'd0, 9'd0, "lk9_miss");
        lookup(8'd7, 1'b1, 9'd10, 9'd20, "lk7");

        // space stall: used 60 + 8 > 64; releasing head (len 10) grants on the next cycle
        start_store(8'd20, 9'd8, 1'b0, 9'd60, 1'b1);
        expect_stall(5, "space");
        I_Req_Release = 1'b1;
        I_ThreadID_Release = 8'd5;
        @(negedge clock);
        check("space_rel_cycle_noack", 32'(O_Ack_St), 32'd0);
        check("space_state_grant", 32'(O_Dbg_State), 32'(MM_GRANT));
        tick();
        I_Req_Release = 1'b0;
        check("space_rel_err", 32'(O_Err_Release), 32'd0);
        wait_ack(3, 0, "space_grant");
        finish_store();
        check("space_used", 32'(O_Used_Size), 32'd58);

        // fill the table to 16 entries, ending with used == memory size
        m_alloc = 4;
        m_used  = 58;
        for (int i = 0; i < 12; i++) begin
            int len;
            len = (i < 6) ? 1 : 0;
            start_store(id_t'(100 + i), mpu_address_t'(len), 1'b0, mpu_address_t'(m_alloc), 1'b1);
            wait_ack(6, 2, $sformatf("fill%0d", i));
            finish_store();
            m_alloc = (m_alloc + len) % MEM;
            m_used  = m_used + len;
        end
        check("fill_used", 32'(O_Used_Size), 32'(m_used));
        check("fill_full", 32'(O_Full), 32'd1);
        lookup(8'd105, 1'b1, 9'd9, 9'd1, "lk105");

        // full stall; release in the grant cycle lets the grant reuse the slot at once
        start_store(8'd200, 9'd0, 1'b0, mpu_address_t'(m_alloc), 1'b1);
        expect_stall(4, "full");
        I_Req_Release = 1'b1;
        I_ThreadID_Release = 8'd7;
        @(negedge clock);
        check("full_rel_ack", 32'(O_Ack_St), 32'd1);
        if (O_Ack_St === 1'b1) take_ack("full_rel");
        check("full_rel_full", 32'(O_Full), 32'd1);
        tick();
        I_Req_Release = 1'b0;
        check("full_after_full", 32'(O_Full), 32'd1);
        check("full_after_err", 32'(O_Err_Release), 32'd0);
        finish_store();
        check("full_after_used", 32'(O_Used_Size), 32'(m_used - 20));
        lookup(8'd7, 1'b0, 9'd0, 9'd0, "lk7_gone");
        lookup(8'd200, 1'b1, mpu_address_t'(m_alloc), 9'd0, "lk200");

        // ID mismatch still releases the head (ID 12, length 0)
        I_Req_Release = 1'b1;
        I_ThreadID_Release = 8'd99;
        tick();
        I_Req_Release = 1'b0;
        check("mism_err", 32'(O_Err_Release), 32'd1);
        check("mism_full", 32'(O_Full), 32'd0);
        check("mism_used", 32'(O_Used_Size), 32'(m_used - 20));
        tick();
        check("mism_err_pulse", 32'(O_Err_Release), 32'd0);
        lookup(8'd12, 1'b0, 9'd0, 9'd0, "lk12_gone");

        // release on empty table
        do_reset();
        I_Req_Release = 1'b1;
        I_ThreadID_Release = 8'd0;
        tick();
        I_Req_Release = 1'b0;
        check("empty_err", 32'(O_Err_Release), 32'd1);
        check("empty_used", 32'(O_Used_Size), 32'd0);
        tick();
        check("empty_err_pulse", 32'(O_Err_Release), 32'd0);

        // asynchronous reset while stalled in grant
        start_store(8'd1, 9'd10, 1'b0, 9'd0, 1'b1);
        wait_ack(6, 2, "pre_rst");
        finish_store();
        start_store(8'd2, 9'd60, 1'b0, 9'd0, 1'b0);
        expect_stall(4, "rst_stall");
        check("rst_stall_state", 32'(O_Dbg_State), 32'(MM_GRANT));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_state", 32'(O_Dbg_State), 32'(MM_IDLE));
        check("midrst_ack", 32'(O_Ack_St), 32'd0);
        check("midrst_used", 32'(O_Used_Size), 32'd0);
        check("midrst_full", 32'(O_Full), 32'd0);
        I_Req_St = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        lookup(8'd1, 1'b0, 9'd0, 9'd0, "lk1_cleared");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
